ex_div_ctrl: RTL and testbench

//  Multi-cycle integer divide sequencer for the EX stage. Accepts one DIV.W/MOD.W/DIV.WU/MOD.WU
//  op from EX and runs a radix-2 restoring divide, one quotient bit per cycle. It holds the result

---
 rtl/ex_div_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ex_div_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer for the EX stage (DIV.W/MOD.W/DIV.WU/MOD.WU).
// Optional feature macro: DIV_ZERO_FAST_EN (a zero divisor skips CALC and goes straight to DONE).
module ex_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             div_start,
    input  logic [1:0]       div_op,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             out_ready,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] div_result
);

    // Handshake: an op is taken when div_start=1 in IDLE; the result transfers when div_done=1
    // and out_ready=1 on the same posedge. div_start is ignored whenever div_busy=1.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             neg1_q, neg1_d;
    logic             neg2_q, neg2_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] mag1_q, mag1_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic             in_neg1, in_neg2, in_zero;
    logic [WIDTH-1:0] in_mag1, in_mag2;
    logic [WIDTH:0]   rem_sh;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_n, quo_n;

    // Sign fixup and divide-by-zero forcing; the sign flags are already zero for unsigned ops.
    function automatic logic [WIDTH-1:0] fixup(input logic [1:0] op, input logic n1,
                                               input logic n2, input logic z,
                                               input logic [WIDTH-1:0] m1,
                                               input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] r);
        logic             sgn;
        logic [WIDTH-1:0] qv, rv;
        sgn = ~op[1];
        qv  = z ? '1 : ((sgn & (n1 ^ n2)) ? -q : q);
        rv  = z ? ((sgn & n1) ? -m1 : m1) : ((sgn & n1) ? -r : r);
        return op[0] ? rv : qv;
    endfunction

    assign in_neg1 = div_src1[WIDTH-1] & ~div_op[1];
    assign in_neg2 = div_src2[WIDTH-1] & ~div_op[1];
    assign in_mag1 = in_neg1 ? -div_src1 : div_src1;
    assign in_mag2 = in_neg2 ? -div_src2 : div_src2;
    assign in_zero = (div_src2 == '0);

    // One restoring step: shift {rem,quo} left, subtract the divisor if it fits.
    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign trial_ok = (rem_sh >= {1'b0, dvsr_q});
    assign rem_n    = trial_ok ? (rem_sh[WIDTH-1:0] - dvsr_q) : rem_sh[WIDTH-1:0];
    assign quo_n    = {quo_q[WIDTH-2:0], trial_ok};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg1_d  = neg1_q;
        neg2_d  = neg2_q;
        zero_d  = zero_q;
        mag1_d  = mag1_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (div_start && !flush) begin
                    op_d   = div_op;
                    neg1_d = in_neg1;
                    neg2_d = in_neg2;
                    zero_d = in_zero;
                    mag1_d = in_mag1;
                    dvsr_d = in_mag2;
                    rem_d  = '0;
                    quo_d  = in_mag1;
                    cnt_d  = '0;
`ifdef DIV_ZERO_FAST_EN
                    if (in_zero) begin
                        state_d = S_DONE;
                        res_d   = fixup(div_op, in_neg1, in_neg2, 1'b1, in_mag1, '0, '0);
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    res_d   = fixup(op_q, neg1_q, neg2_q, zero_q, mag1_q, quo_n, rem_n);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush beats every other transition, including a result about to be loaded.
        if (flush) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            zero_q  <= 1'b0;
            mag1_q  <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg1_q  <= neg1_d;
            neg2_q  <= neg2_d;
            zero_q  <= zero_d;
            mag1_q  <= mag1_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
        end
    end

    assign div_busy   = (state_q != S_IDLE);
    assign div_done   = (state_q == S_DONE);
    assign div_result = res_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: directed cases, hold/flush/reset scenarios and random ops
// scored against an arithmetic reference model through an expected-result queue.
module tb_ex_div_ctrl;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          div_start;
    logic [1:0]    div_op;
    logic [W-1:0]  div_src1;
    logic [W-1:0]  div_src2;
    logic          out_ready;
    logic          div_busy;
    logic          div_done;
    logic [W-1:0]  div_result;

    logic [W-1:0]  exp_q[$];
    int            lat_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    bit            mon_en = 1'b0;
    bit            done_seen = 1'b0;
    bit            rdy_rand = 1'b0;

    ex_div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .div_start  (div_start),
        .div_op     (div_op),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .out_ready  (out_ready),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] q, r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!op[1]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[0] ? r : q;
    endfunction

    // Cycle (accept = cycle 0) in which div_done first reads 1.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == '0) ? 1 : W + 1;
`else
        if (b == '0) return W + 1;
        return W + 1;
`endif
    endfunction

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                done_seen = 1'b0;
            end else begin
                if (div_done && !done_seen) begin
                    done_seen = 1'b1;
                    if (lat_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 expected no pending op");
                    end else begin
                        check("latency", 32'(cyc - acc_cyc + 1), 32'(lat_q[0]));
                    end
                end
                if (div_done && out_ready) begin
                    done_seen = 1'b0;
                    if (exp_q.size() != 0) begin
                        check("result", div_result, exp_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (div_busy && n < 500) begin
            tick();
            n++;
        end
        if (div_busy) check("idle_timeout", 32'(div_busy), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!div_done && n < 200) begin
            tick();
            n++;
        end
        check("done_reached", 32'(div_done), 32'd1);
    endtask

    task automatic start_raw(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        div_start = 1'b1;
        div_op    = op;
        div_src1  = a;
        div_src2  = b;
        tick();
        acc_cyc   = cyc;
        div_start = 1'b0;
        div_op    = 2'($urandom_range(0, 3));
        div_src1  = $urandom;
        div_src2  = $urandom;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expv);
        wait_idle();
        exp_q.push_back(expv);
        lat_q.push_back(exp_lat(b));
        start_raw(op, a, b);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, b;
        rst       = 1'b1;
        flush     = 1'b0;
        div_start = 1'b0;
        div_op    = 2'd0;
        div_src1  = '0;
        div_src2  = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(div_busy), 32'd0);
        check("rst_done", 32'(div_done), 32'd0);
        check("rst_result", div_result, 32'd0);
        rst       = 1'b0;
        mon_en    = 1'b1;
        out_ready = 1'b1;

        // Directed arithmetic cases with hand-derived results.
        do_op(2'd2, 32'd100, 32'd7, 32'd14);
        do_op(2'd3, 32'd100, 32'd7, 32'd2);
        do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_op(2'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op(2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF);
        do_op(2'd1, 32'd5, 32'd0, 32'd5);
        do_op(2'd1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

        // Hold in DONE with start requests that must be ignored.
        wait_idle();
        out_ready = 1'b0;
        do_op(2'd2, 32'd100, 32'd7, 32'd14);
        wait_done();
        for (int i = 0; i < 10; i++) begin
            div_start = 1'b1;
            div_op    = 2'($urandom_range(0, 3));
            div_src1  = $urandom;
            div_src2  = $urandom;
            tick();
            check("hold_done", 32'(div_done), 32'd1);
            check("hold_result", div_result, 32'd14);
        end
        div_op    = 2'd3;
        div_src1  = 32'd100;
        div_src2  = 32'd7;
        out_ready = 1'b1;
        tick();
        check("exit_ignores_start", 32'(div_busy), 32'd0);
        exp_q.push_back(32'd2);
        lat_q.push_back(W + 1);
        tick();
        acc_cyc   = cyc;
        check("next_accept", 32'(div_busy), 32'd1);
        div_start = 1'b0;

        // Flush during CALC cycle 10, then a clean op.
        start_raw(2'd2, 32'd1000, 32'd3);
        repeat (9) tick();
        check("pre_flush_busy", 32'(div_busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 32'(div_busy), 32'd0);
        check("flush_done", 32'(div_done), 32'd0);
        do_op(2'd2, 32'd9, 32'd3, 32'd3);

        // Reset mid-CALC and in DONE.
        wait_idle();
        mon_en = 1'b0;
        start_raw(2'd2, 32'd100, 32'd7);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_calc_busy", 32'(div_busy), 32'd0);
        check("rst_calc_done", 32'(div_done), 32'd0);
        check("rst_calc_result", div_result, 32'd0);
        out_ready = 1'b0;
        start_raw(2'd2, 32'd100, 32'd7);
        wait_done();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_done_busy", 32'(div_busy), 32'd0);
        check("rst_done_done", 32'(div_done), 32'd0);
        check("rst_done_result", div_result, 32'd0);
        tick();
        mon_en    = 1'b1;
        out_ready = 1'b1;

        // Random ops with random downstream back-pressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 50)); end
                2: begin a = $urandom; b = '0; end
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin
                    a = 32'd0 - 32'($urandom_range(1, 1000));
                    b = ($urandom_range(0, 1) == 0) ? 32'd0 - 32'($urandom_range(1, 20))
                                                    : 32'($urandom_range(1, 20));
                end
                default: begin a = 32'($urandom_range(0, 10)); b = $urandom | 32'h100; end
            endcase
            do_op(op, a, b, model(op, a, b));
        end

        // Drain.
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
